// File: rtl/trans_sched_if.sv
// Requester-side beat bus plus packer drive bundle for trans_sched.
// The packer's byte-mode select is named byte_sel because "byte" is a reserved word.
interface trans_sched_if #(
  parameter int NREQ = 2
);
  // Handshake: a beat from requester i moves on a rising clk edge where
  // src_valid[i] && src_ready[i]; src_byte/src_data/src_last must be stable
  // while src_valid is high, and src_ready never depends on src_valid.
  logic [NREQ-1:0]   src_valid;
  logic [NREQ-1:0]   src_byte;
  logic [8*NREQ-1:0] src_data;
  logic [NREQ-1:0]   src_last;
  logic [NREQ-1:0]   src_ready;
  logic              start;
  logic              byte_sel;
  logic [7:0]        data_in;

  modport master (
    output src_valid, src_byte, src_data, src_last,
    input  src_ready, start, byte_sel, data_in
  );

  modport slave (
    input  src_valid, src_byte, src_data, src_last,
    output src_ready, start, byte_sel, data_in
  );
endinterface

// File: rtl/trans_sched.sv
// Round-robin frame scheduler feeding one byte/nibble packer; pads odd nibble frames.
// Optional stall watchdog enabled by defining TRANS_SCHED_TIMEOUT_EN.
module trans_sched #(
  parameter int NREQ    = 2,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  trans_sched_if.slave    sif,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            frame_done,
  output logic            err_timeout,
  output logic [1:0]      dbg_state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] RR_RST   = IW'(NREQ - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_PAD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            mode_q, mode_d;
  logic            phase_q, phase_d;
  logic            start_q, start_d;
  logic            byte_q, byte_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      gap_q, gap_d;

  logic            arb_found;
  logic [IW-1:0]   arb_idx;
  logic [NREQ-1:0] arb_oh;
  logic [7:0]      sel_data;
  logic            accept;
  logic            last_b;
  logic            close_frame;

`ifdef TRANS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
`endif

  assign sif.src_ready = (state_q == S_XFER) ? grant_q : '0;
  assign accept        = |(sif.src_valid & sif.src_ready);
  assign last_b        = |(sif.src_last & grant_q);

  // First requesting index strictly after rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_oh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!arb_found && (j == (int'(rr_ptr_q) + k) % NREQ) && sif.src_valid[j]) begin
          arb_found = 1'b1;
          arb_idx   = IW'(j);
          arb_oh[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gidx_q == IW'(j)) sel_data = sif.src_data[8*j +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    mode_d      = mode_q;
    phase_d     = phase_q;
    start_d     = 1'b0;
    byte_d      = byte_q;
    data_d      = data_q;
    done_d      = 1'b0;
    gap_d       = gap_q;
    close_frame = 1'b0;
`ifdef TRANS_SCHED_TIMEOUT_EN
    to_d        = to_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_XFER;
          grant_d = arb_oh;
          gidx_d  = arb_idx;
          mode_d  = |(sif.src_byte & arb_oh);
          phase_d = 1'b0;
`ifdef TRANS_SCHED_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      S_XFER: begin
        if (accept) begin
          start_d = 1'b1;
          byte_d  = mode_q;
          data_d  = sel_data;
          if (!mode_q) phase_d = ~phase_q;
`ifdef TRANS_SCHED_TIMEOUT_EN
          to_d    = '0;
`endif
          // An odd nibble count leaves the packer mid-byte, so flush with a pad.
          if (last_b) begin
            if (!mode_q && !phase_q) state_d = S_PAD;
            else                     close_frame = 1'b1;
          end
        end
`ifdef TRANS_SCHED_TIMEOUT_EN
        else begin
          to_d = to_q + 1'b1;
          if (to_d == TW'(TIMEOUT)) begin
            err_d = 1'b1;
            if (phase_q) state_d = S_PAD;
            else         close_frame = 1'b1;
          end
        end
`endif
      end
      S_PAD: begin
        start_d     = 1'b1;
        byte_d      = 1'b0;
        data_d      = 8'h00;
        phase_d     = 1'b0;
        close_frame = 1'b1;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // frame_done coincides with the final packer beat being registered.
    if (close_frame) begin
      done_d   = 1'b1;
      rr_ptr_d = gidx_q;
      if (GAP_CYC == 0) begin
        state_d = S_IDLE;
        grant_d = '0;
      end else begin
        state_d = S_GAP;
        gap_d   = 4'd0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= RR_RST;
      mode_q   <= 1'b0;
      phase_q  <= 1'b0;
      start_q  <= 1'b0;
      byte_q   <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      start_q  <= start_d;
      byte_q   <= byte_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gap_q    <= gap_d;
    end
  end

`ifdef TRANS_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  // No watchdog in this build; TIMEOUT is inert and the flag stays low.
  assign err_timeout = (TIMEOUT < 0);
`endif

  assign sif.start    = start_q;
  assign sif.byte_sel = byte_q;
  assign sif.data_in  = data_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_trans_sched.sv
// Directed and randomized checks of trans_sched against a frame-level model.
module tb_trans_sched;
  localparam int NREQ = 2;
  localparam int MAXF = 4;
  localparam int MAXB = 5;
  localparam int W    = NREQ + 10;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] grant;
  logic            busy, frame_done, err_timeout;
  logic [1:0]      dbg_state;

  trans_sched_if #(.NREQ(NREQ)) ifc ();

  trans_sched #(.NREQ(NREQ), .GAP_CYC(1), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .sif(ifc),
    .grant(grant), .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    ifc.src_valid = '0;
    ifc.src_byte  = '0;
    ifc.src_data  = '0;
    ifc.src_last  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Present one beat and return at the negedge after it was accepted.
  task automatic drive_beat(input int r, input logic b, input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    ifc.src_valid[r]       = 1'b1;
    ifc.src_byte[r]        = b;
    ifc.src_data[8*r +: 8] = d;
    ifc.src_last[r]        = l;
    for (int k = 0; k < 40 && !ok; k++) begin
      #1;
      if (ifc.src_ready[r]) ok = 1'b1;
      @(negedge clk);
    end
    ifc.src_valid[r] = 1'b0;
    chk("accept_wait", {31'd0, ok}, 32'd1);
  endtask

  int            flen [NREQ][MAXF];
  bit            fmode[NREQ][MAXF];
  logic [7:0]    fdat [NREQ][MAXF][MAXB];
  int            nfr  [NREQ];

  // Frame-level model: round-robin over requesters that still have frames,
  // every frame expands to its beats plus a pad when nibble count is odd.
  task automatic build_expect();
    int rem[NREQ];
    int ptr, c, f;
    bit any;
    logic [NREQ-1:0] oh;
    for (int r = 0; r < NREQ; r++) rem[r] = nfr[r];
    ptr = NREQ - 1;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      c = -1;
      for (int k = 1; k <= NREQ && c < 0; k++)
        if (rem[(ptr + k) % NREQ] > 0) c = (ptr + k) % NREQ;
      if (c >= 0) begin
        any = 1'b1;
        f   = nfr[c] - rem[c];
        oh  = '0;
        oh[c] = 1'b1;
        for (int b = 0; b < flen[c][f]; b++)
          exp_q.push_back({oh, fmode[c][f], fdat[c][f][b],
                           (b == flen[c][f] - 1) && (fmode[c][f] || (flen[c][f] % 2 == 0))});
        if (!fmode[c][f] && (flen[c][f] % 2 == 1))
          exp_q.push_back({oh, 1'b0, 8'h00, 1'b1});
        rem[c]--;
        ptr = c;
      end
    end
  endtask

  initial begin : main
    logic [3:0] nib[4];
    int fi[NREQ], bi[NREQ];
    bit acc[NREQ];
    bit finished;
    logic [W-1:0] e;

    // Reset state
    do_reset();
    chk("rst_start", ifc.start, 0);
    chk("rst_byte", ifc.byte_sel, 0);
    chk("rst_data", ifc.data_in, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_state", dbg_state, 0);

    // Req0 byte frame A1,B2,C3
    ifc.src_valid[0] = 1'b1; ifc.src_byte[0] = 1'b1;
    ifc.src_data[7:0] = 8'hA1; ifc.src_last[0] = 1'b0;
    @(negedge clk);
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_ready", ifc.src_ready, 2'b01);
    chk("t1_start0", ifc.start, 0);
    drive_beat(0, 1'b1, 8'hA1, 1'b0);
    chk("t1_a1", {ifc.start, ifc.byte_sel, ifc.data_in, frame_done}, {1'b1, 1'b1, 8'hA1, 1'b0});
    drive_beat(0, 1'b1, 8'hB2, 1'b0);
    chk("t1_b2", {ifc.start, ifc.byte_sel, ifc.data_in, frame_done}, {1'b1, 1'b1, 8'hB2, 1'b0});
    drive_beat(0, 1'b1, 8'hC3, 1'b1);
    chk("t1_c3", {ifc.start, ifc.byte_sel, ifc.data_in, frame_done}, {1'b1, 1'b1, 8'hC3, 1'b1});
    chk("t1_c3_grant", grant, 2'b01);
    @(negedge clk);
    chk("t1_gap_start", ifc.start, 0);
    chk("t1_gap_done", frame_done, 0);
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_busy", busy, 0);

    // Req1 nibble frame 05,0A,03 with pad
    drive_beat(1, 1'b0, 8'h05, 1'b0);
    chk("t2_05", {grant, ifc.start, ifc.byte_sel, ifc.data_in}, {2'b10, 1'b1, 1'b0, 8'h05});
    nib[0] = ifc.data_in[3:0];
    drive_beat(1, 1'b0, 8'h0A, 1'b0);
    chk("t2_0a", {ifc.start, ifc.byte_sel, ifc.data_in}, {1'b1, 1'b0, 8'h0A});
    nib[1] = ifc.data_in[3:0];
    drive_beat(1, 1'b0, 8'h03, 1'b1);
    chk("t2_03", {ifc.start, ifc.data_in, frame_done}, {1'b1, 8'h03, 1'b0});
    nib[2] = ifc.data_in[3:0];
    @(negedge clk);
    chk("t2_pad", {ifc.start, ifc.byte_sel, ifc.data_in, frame_done}, {1'b1, 1'b0, 8'h00, 1'b1});
    nib[3] = ifc.data_in[3:0];
    chk("t2_pack0", {nib[0], nib[1]}, 8'h5A);
    chk("t2_pack1", {nib[2], nib[3]}, 8'h30);
    @(negedge clk);
    chk("t2_after", ifc.start, 0);

    // Req0 byte frame with a 3-cycle valid gap
    drive_beat(0, 1'b1, 8'h11, 1'b0);
    chk("t4_11", {ifc.start, ifc.data_in}, {1'b1, 8'h11});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall", {ifc.start, ifc.byte_sel, ifc.data_in, busy}, {1'b0, 1'b1, 8'h11, 1'b1});
    end
    drive_beat(0, 1'b1, 8'h22, 1'b1);
    chk("t4_22", {ifc.start, ifc.data_in, frame_done}, {1'b1, 8'h22, 1'b1});
    @(negedge clk);
    chk("t4_nopad", {ifc.start, frame_done}, 2'b00);

    // Reset in the middle of a req1 nibble frame
    drive_beat(1, 1'b0, 8'h07, 1'b0);
    chk("t5_07", {grant, ifc.data_in}, {2'b10, 8'h07});
    ifc.src_valid[1] = 1'b1; ifc.src_data[15:8] = 8'h09;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async", {ifc.start, ifc.byte_sel, ifc.data_in, grant, busy, frame_done, err_timeout},
        14'd0);
    chk("t5_ready", ifc.src_ready, 0);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    ifc.src_valid = 2'b11; ifc.src_byte = 2'b11;
    @(negedge clk);
    chk("t5_first_grant", grant, 2'b01);

    // Randomized frames from both requesters
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      nfr[r] = $urandom_range(2, MAXF);
      for (int f = 0; f < MAXF; f++) begin
        flen[r][f]  = $urandom_range(1, MAXB);
        fmode[r][f] = 1'($urandom_range(0, 1));
        for (int b = 0; b < MAXB; b++)
          fdat[r][f][b] = fmode[r][f] ? 8'($urandom) : {4'h0, 4'($urandom)};
      end
      fi[r] = 0; bi[r] = 0; acc[r] = 1'b0;
    end
    build_expect();
    finished = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      chk("r_onehot", {31'd0, $onehot0(grant)}, 1);
      chk("r_ready_sub", |(ifc.src_ready & ~grant), 0);
      if (ifc.start) begin
        if (exp_q.size() == 0) chk("r_extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("r_beat", {grant, ifc.byte_sel, ifc.data_in, frame_done}, e);
        end
      end else begin
        chk("r_done_idle", frame_done, 0);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r]) begin
          bi[r]++;
          if (bi[r] == flen[r][fi[r]]) begin
            fi[r]++;
            bi[r] = 0;
          end
        end
        if (fi[r] < nfr[r]) begin
          ifc.src_valid[r]       = (bi[r] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          ifc.src_byte[r]        = (bi[r] == 0) ? fmode[r][fi[r]] : 1'($urandom);
          ifc.src_data[8*r +: 8] = fdat[r][fi[r]][bi[r]];
          ifc.src_last[r]        = (bi[r] == flen[r][fi[r]] - 1);
        end else begin
          ifc.src_valid[r] = 1'b0;
          ifc.src_last[r]  = 1'b0;
        end
      end
      #1;
      for (int r = 0; r < NREQ; r++) acc[r] = ifc.src_valid[r] && ifc.src_ready[r];
      finished = (exp_q.size() == 0) && (fi[0] == nfr[0]) && (fi[1] == nfr[1]);
    end
    chk("r_drained", exp_q.size(), 0);
    chk("r_frames0", fi[0], nfr[0]);
    chk("r_frames1", fi[1], nfr[1]);
    repeat (3) @(negedge clk);
    chk("r_end_idle", {busy, grant, ifc.start}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
